reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have port i_wb_rd_index, input, 5, destination register index from the write-back stage.
REQ-004 SHALL have port i_wb_rd_data, input, 64, write data from the write-back stage.
REQ-005 SHALL have port i_wb_rd_we, input, 1, write enable from the write-back stage.
REQ-006 SHALL have ports i_rs1_index and i_rs2_index, input, 5 each, read-port indices from decode.
REQ-007 SHALL have ports o_rs1_data and o_rs2_data, output, 64 each, read-port data.
REQ-008 SHALL have ports o_rs1_ready and o_rs2_ready, output, 1 each, operand has no pending write.
REQ-009 SHALL have port i_issue_valid, input, 1, decode issues an instruction that writes a register.
REQ-010 SHALL have port i_issue_rd, input, 5, destination index of the issued instruction.
REQ-011 SHALL have port o_issue_stall, output, 1, issue refused this cycle.
REQ-012 SHALL have port o_sb_err, output, 1, sticky scoreboard underflow flag.

Function
REQ-013 SHALL hold 32 x 64-bit registers; x0 reads 0 always, and writes to x0 are discarded.
REQ-014 SHALL write i_wb_rd_data to register i_wb_rd_index on the rising edge when i_wb_rd_we=1 and the index is not 0.
REQ-015 SHALL provide combinational reads; o_rsN_data equals the stored register, subject to the bypass rule in Configuration.
REQ-016 SHALL keep one 2-bit pending counter per register, index 1..31; x0 has no counter and is always ready.
REQ-017 SHALL accept an issue when i_issue_valid=1 and o_issue_stall=0; accepted issue to rd!=0 increments counter[rd].
REQ-018 SHALL drive o_issue_stall=1, combinationally, when i_issue_valid=1, i_issue_rd!=0, counter[i_issue_rd]=3, and no write-back to that index occurs this cycle; the counter then holds.
REQ-019 SHALL decrement counter[i_wb_rd_index] on each write-back with i_wb_rd_we=1 and index!=0.
REQ-020 SHALL leave the counter unchanged when an accepted issue and a write-back target the same register in the same cycle.
REQ-021 SHALL, on a write-back to a register whose counter is 0 with no same-cycle issue, leave the counter at 0 and set o_sb_err=1 until reset.
REQ-022 SHALL still perform the register-array write in the underflow case of REQ-021.
REQ-023 SHALL drive o_rsN_ready=1 when rsN=0 or counter[rsN]=0, otherwise 0, except as extended in Configuration.
REQ-024 SHALL resolve an issue and read of the same index in one cycle by reporting ready from the pre-issue counter value.

Reset
REQ-025 SHALL, while i_rst=1, clear all registers to 0, all counters to 0, and o_sb_err to 0, independent of i_clk.
REQ-026 SHALL, while i_rst=1, drive o_rsN_data=0, o_rsN_ready=1 and o_issue_stall=0.
REQ-027 SHALL ignore write-back and issue inputs presented during reset; reset mid-operation discards all pending state.

Configuration
REQ-028 SHALL use macro REG_FILE_BYPASS_EN.
REQ-029 SHALL, with the macro defined, forward a same-cycle write-back: when i_wb_rd_we=1 and i_wb_rd_index=rsN!=0, o_rsN_data=i_wb_rd_data.
REQ-030 SHALL, with the macro defined in the REQ-029 case, also drive o_rsN_ready=1 when counter[rsN]=1.
REQ-031 SHALL, with the macro undefined, return the pre-write stored value and apply REQ-023 unmodified; new data is visible one cycle after the write.

Verification
REQ-032 SHALL cover write x5=0x0123_4567_89AB_CDEF, then read rs1=5 -> o_rs1_data=0x0123_4567_89AB_CDEF next cycle.
REQ-033 SHALL cover write x0=0xFFFF_FFFF_FFFF_FFFF, then read rs2=0 -> o_rs2_data=0, o_rs2_ready=1.
REQ-034 SHALL cover an issue of rd=7 with no write-back -> o_rs1_ready=0 for rs1=7 until write-back of x7, then ready=1 and data correct.
REQ-035 SHALL cover four issues to rd=9 without write-back -> the fourth has o_issue_stall=1 and the counter stays 3; three write-backs -> ready.
REQ-036 SHALL cover a same-cycle write x3=0xAA and read rs1=3 -> 0xAA with ready=1 when bypass is enabled; the old value and ready=0 when disabled, given counter=1.
REQ-037 SHALL cover a write-back to x4 with counter 0 -> o_sb_err=1 persists; asserting i_rst mid-stream -> all registers 0, o_sb_err=0.

Source files
------------

// File: rtl/reg_file.sv
// 32 x 64-bit register file with per-register 2-bit pending-write scoreboard.
// Optional write-back-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_wb_rd_index,
    input  logic [63:0] i_wb_rd_data,
    input  logic        i_wb_rd_we,
    input  logic [4:0]  i_rs1_index,
    input  logic [4:0]  i_rs2_index,
    output logic [63:0] o_rs1_data,
    output logic [63:0] o_rs2_data,
    output logic        o_rs1_ready,
    output logic        o_rs2_ready,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_rd,
    output logic        o_issue_stall,
    output logic        o_sb_err
);

    logic [63:0] regs_q [32];
    logic [1:0]  cnt_q  [32];
    logic [1:0]  cnt_d  [32];
    logic        sb_err_q, sb_err_d;

    logic        wb_en;
    logic        stall_raw;
    logic        issue_acc;
    logic [31:0] inc_hit;
    logic [31:0] dec_hit;

    assign wb_en = i_wb_rd_we && (i_wb_rd_index != 5'd0);

    // A write-back to the same register this cycle frees a slot, so no stall.
    assign stall_raw = i_issue_valid && (i_issue_rd != 5'd0) &&
                       (cnt_q[i_issue_rd] == 2'd3) &&
                       !(wb_en && (i_wb_rd_index == i_issue_rd));
    assign issue_acc     = i_issue_valid && !stall_raw;
    assign o_issue_stall = stall_raw && !i_rst;
    assign o_sb_err      = sb_err_q;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_hit
            if (gi == 0) begin : g_x0
                assign inc_hit[gi] = 1'b0;
                assign dec_hit[gi] = 1'b0;
            end else begin : g_xn
                assign inc_hit[gi] = issue_acc && (i_issue_rd == 5'(gi));
                assign dec_hit[gi] = wb_en && (i_wb_rd_index == 5'(gi));
            end
        end
    endgenerate

    always_comb begin
        sb_err_d = sb_err_q;
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            case ({inc_hit[r], dec_hit[r]})
                2'b10: cnt_d[r] = cnt_q[r] + 2'd1;
                2'b01: begin
                    if (cnt_q[r] == 2'd0) sb_err_d = 1'b1;
                    else                  cnt_d[r] = cnt_q[r] - 2'd1;
                end
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < 32; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            if (wb_en) regs_q[i_wb_rd_index] <= i_wb_rd_data;
            for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
            sb_err_q <= sb_err_d;
        end
    end

    logic [4:0]  rs_idx   [2];
    logic [63:0] rs_data  [2];
    logic        rs_ready [2];

    assign rs_idx[0]   = i_rs1_index;
    assign rs_idx[1]   = i_rs2_index;
    assign o_rs1_data  = rs_data[0];
    assign o_rs2_data  = rs_data[1];
    assign o_rs1_ready = rs_ready[0];
    assign o_rs2_ready = rs_ready[1];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rs_data[p]  = regs_q[rs_idx[p]];
            rs_ready[p] = (cnt_q[rs_idx[p]] == 2'd0);
`ifdef REG_FILE_BYPASS_EN
            // The last outstanding write landing now makes the operand usable.
            if (wb_en && (i_wb_rd_index == rs_idx[p])) begin
                rs_data[p] = i_wb_rd_data;
                if (cnt_q[rs_idx[p]] == 2'd1) rs_ready[p] = 1'b1;
            end
`endif
            if (rs_idx[p] == 5'd0 || i_rst) begin
                rs_data[p]  = '0;
                rs_ready[p] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: driver pushes model expectations, monitor compares at negedge.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_idx;
    logic [63:0] wb_data;
    logic        wb_we;
    logic [4:0]  rs1, rs2;
    logic [63:0] rs1_data, rs2_data;
    logic        rs1_ready, rs2_ready;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        stall, sb_err;

    always #5 clk = ~clk;

    reg_file dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_rd_index(wb_idx), .i_wb_rd_data(wb_data), .i_wb_rd_we(wb_we),
        .i_rs1_index(rs1), .i_rs2_index(rs2),
        .o_rs1_data(rs1_data), .o_rs2_data(rs2_data),
        .o_rs1_ready(rs1_ready), .o_rs2_ready(rs2_ready),
        .i_issue_valid(iss_v), .i_issue_rd(iss_rd),
        .o_issue_stall(stall), .o_sb_err(sb_err)
    );

    typedef struct {
        int          id;
        logic [63:0] d1;
        logic        r1;
        logic [63:0] d2;
        logic        r2;
        logic        st;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: register contents, outstanding write count, sticky error.
    logic [63:0] mem  [32];
    int          pend [32];
    bit          err_m;
    int          n_total = 0;
    int          n_pass  = 0;
    int          txn     = 0;
    bit          byp;

    initial begin
`ifdef REG_FILE_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
    end

    function automatic logic [63:0] m_data(input logic [4:0] idx);
        if (idx == 0) return 64'd0;
        if (byp && wb_we && wb_idx == idx) return wb_data;
        return mem[idx];
    endfunction

    function automatic logic m_ready(input logic [4:0] idx);
        if (idx == 0 || pend[idx] == 0) return 1'b1;
        if (byp && wb_we && wb_idx == idx && pend[idx] == 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input logic r, input logic we, input logic [4:0] wi,
                         input logic [63:0] wd, input logic v, input logic [4:0] rd,
                         input logic [4:0] a, input logic [4:0] b);
        exp_t e;
        bit   st, acc, wbv;
        @(posedge clk);
        #1;
        rst = r; wb_we = we; wb_idx = wi; wb_data = wd;
        iss_v = v; iss_rd = rd; rs1 = a; rs2 = b;
        e.id = txn; txn++;
        if (r) begin
            e.d1 = 0; e.r1 = 1; e.d2 = 0; e.r2 = 1; e.st = 0; e.err = 0;
            for (int i = 0; i < 32; i++) begin mem[i] = 0; pend[i] = 0; end
            err_m = 0;
        end else begin
            wbv = we && wi != 0;
            st  = v && rd != 0 && pend[rd] == 3 && !(wbv && wi == rd);
            e.d1 = m_data(a); e.r1 = m_ready(a);
            e.d2 = m_data(b); e.r2 = m_ready(b);
            e.st = st; e.err = err_m;
            acc = v && !st && rd != 0;
            if (wbv) mem[wi] = wd;
            if (!(acc && wbv && wi == rd)) begin
                if (acc) pend[rd]++;
                if (wbv) begin
                    if (pend[wi] == 0) err_m = 1;
                    else pend[wi]--;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s txn %0d: got %h want %h", name, id, act, want);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rs1_data",  e.id, rs1_data,  e.d1);
            chk("rs1_ready", e.id, 64'(rs1_ready), 64'(e.r1));
            chk("rs2_data",  e.id, rs2_data,  e.d2);
            chk("rs2_ready", e.id, 64'(rs2_ready), 64'(e.r2));
            chk("stall",     e.id, 64'(stall),     64'(e.st));
            chk("sb_err",    e.id, 64'(sb_err),    64'(e.err));
            $display("txn %0d rst=%0b we=%0b wi=%0d iss=%0b rd=%0d rs1=%0d:%h/%0b rs2=%0d:%h/%0b st=%0b err=%0b",
                     e.id, rst, wb_we, wb_idx, iss_v, iss_rd, rs1, rs1_data, rs1_ready,
                     rs2, rs2_data, rs2_ready, stall, sb_err);
        end
    end

    initial begin
        rst = 1; wb_we = 0; wb_idx = 0; wb_data = 0; iss_v = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
        for (int i = 0; i < 32; i++) begin mem[i] = 0; pend[i] = 0; end
        err_m = 0;
        drive(1, 0, 0, 0, 0, 0, 5, 9);
        drive(1, 1, 5, 64'h1, 1, 5, 5, 9);
        // x5 write then read
        drive(0, 1, 5, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        // x0 write discarded
        drive(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // x7 pending until write-back
        drive(0, 0, 0, 0, 1, 7, 7, 0);
        drive(0, 0, 0, 0, 0, 0, 7, 7);
        drive(0, 0, 0, 0, 0, 0, 7, 0);
        drive(0, 1, 7, 64'h7777_0000_DEAD_BEEF, 0, 0, 7, 7);
        drive(0, 0, 0, 0, 0, 0, 7, 7);
        // x9 saturates at 3 outstanding, fourth issue stalls
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 9, 9, 0);
        drive(0, 0, 0, 0, 1, 9, 9, 9);
        for (int i = 0; i < 3; i++) drive(0, 1, 9, 64'(100 + i), 0, 0, 9, 0);
        drive(0, 0, 0, 0, 0, 0, 9, 9);
        // counter 3 with same-cycle write-back: issue accepted, count holds
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 9, 0, 0);
        drive(0, 1, 9, 64'h99, 1, 9, 9, 0);
        drive(0, 0, 0, 0, 1, 9, 9, 0);
        // same-cycle write/read of x3 with counter 1
        drive(0, 1, 3, 64'h11, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 3, 0);
        drive(0, 1, 3, 64'hAA, 0, 0, 3, 3);
        drive(0, 0, 0, 0, 0, 0, 3, 0);
        // issue and read same index: ready from pre-issue count
        drive(0, 0, 0, 0, 1, 12, 12, 12);
        drive(0, 1, 12, 64'hC, 0, 0, 12, 0);
        // underflow on x4, sticky until reset
        drive(0, 1, 4, 64'h4444, 0, 0, 4, 0);
        drive(0, 0, 0, 0, 0, 0, 4, 0);
        drive(0, 0, 0, 0, 1, 4, 4, 5);
        drive(1, 1, 4, 64'h5, 1, 4, 4, 5);
        drive(0, 0, 0, 0, 0, 0, 4, 5);
        drive(0, 0, 0, 0, 0, 0, 7, 3);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic        r_r, r_we, r_v;
            logic [4:0]  r_wi, r_rd, r_a, r_b;
            logic [63:0] r_wd;
            r_r  = ($urandom_range(0, 99) == 0);
            r_we = ($urandom_range(0, 2) == 0);
            r_v  = ($urandom_range(0, 1) == 0);
            r_wi = 5'($urandom_range(0, 11));
            r_rd = 5'($urandom_range(0, 11));
            r_a  = 5'($urandom_range(0, 11));
            r_b  = 5'($urandom_range(0, 31));
            r_wd = {$urandom, $urandom};
            drive(r_r, r_we, r_wi, r_wd, r_v, r_rd, r_a, r_b);
        end
        begin
            int k;
            k = 0;
            while (exp_q.size() > 0 && k < 10) begin
                @(posedge clk);
                k++;
            end
            if (exp_q.size() > 0) begin
                n_total++;
                $display("FAIL drain: %0d pending, want 0", exp_q.size());
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
